btb_predictor: RTL and testbench

Parametrised branch target buffer with per-entry 2-bit saturating direction counters and true-LRU replacement. It sits between fetch and execute. Fetch performs a combinational lookup by low PC bits and gets a target plus a taken prediction. Execute posts one resolved-branch update per cycle, which trains the counter, refreshes the target, or allocates a new entry. All state is clocked; there are no latches and no combinational feedback.

---
 rtl/btb_pkg.sv | 41 ++++
 rtl/btb_predictor_lru.sv | 68 ++++++
 rtl/btb_predictor.sv | 156 +++++++++++++++
 tb/tb_btb_predictor.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared types, constants and counter helpers for the branch target buffer.
package btb_pkg;

    localparam int BTB_W_PC     = 8;
    localparam int BTB_W_BTA    = 32;
    localparam int BTB_CTR_BITS = 2;

    // Entry layout at the default widths; the top re-declares it from its own
    // parameters so that width overrides stay consistent.
    typedef struct packed {
        logic                    valid;
        logic [BTB_W_PC-1:0]     tag;
        logic [BTB_W_BTA-1:0]    target;
        logic [BTB_CTR_BITS-1:0] ctr;
    } btb_entry_t;

    // Weakly-taken counter value at the default width.
    localparam logic [BTB_CTR_BITS-1:0] CTR_WEAK_TAKEN = 2'b10;

    // Weakly-taken value for an arbitrary counter width: MSB set, rest clear.
    function automatic logic [31:0] ctr_weak_taken(input int unsigned bits);
        return 32'd1 << (bits - 1);
    endfunction

    // Saturating increment of a bits-wide counter held in the low bits of v.
    function automatic logic [31:0] ctr_sat_inc(input logic [31:0] v, input int unsigned bits);
        logic [63:0] maxv;
        maxv = (64'd1 << bits) - 64'd1;
        if ({32'd0, v} >= maxv)
            return v;
        return v + 32'd1;
    endfunction

    // Saturating decrement, floored at zero.
    function automatic logic [31:0] ctr_sat_dec(input logic [31:0] v);
        if (v == 32'd0)
            return v;
        return v - 32'd1;
    endfunction

endpackage

// File: rtl/btb_predictor_lru.sv
// True-LRU age tracker: keeps a permutation of ages 0..N-1 and picks the
// allocation victim (lowest invalid entry, else the oldest entry).
module btb_lru
    import btb_pkg::*;
#(
    parameter int N_ENTRIES = 4,
    localparam int AW = $clog2(N_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   touch_en,
    input  logic [AW-1:0]          touch_idx,
    input  logic                   alloc_req,
    input  logic [N_ENTRIES-1:0]   valid,
    output logic [AW-1:0]          victim_idx,
    output logic [N_ENTRIES*AW-1:0] ages
);

    logic [AW-1:0] age [N_ENTRIES];
    logic [AW-1:0] sel_idx;
    logic          do_touch;
    logic          found_invalid;

    // Victim: first invalid entry wins; with all valid, the entry aged N-1.
    always_comb begin
        victim_idx    = '0;
        found_invalid = 1'b0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            if (age[i] == AW'(N_ENTRIES - 1))
                victim_idx = AW'(i);
        end
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            if (!found_invalid && !valid[i]) begin
                victim_idx    = AW'(i);
                found_invalid = 1'b1;
            end
        end
    end

    // An allocation touches its own victim; otherwise touch the hit entry.
    always_comb begin
        do_touch = touch_en | alloc_req;
        sel_idx  = alloc_req ? victim_idx : touch_idx;
    end

    // Age update: younger entries than the touched one age by one, touched becomes 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_ENTRIES; i++)
                age[i] <= AW'(i);
        end else if (do_touch) begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                if (AW'(i) == sel_idx)
                    age[i] <= '0;
                else if (age[i] < age[sel_idx])
                    age[i] <= age[i] + 1'b1;
            end
        end
    end

    // Flatten ages for observation by the parent.
    always_comb begin
        ages = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++)
            ages[i*AW +: AW] = age[i];
    end

endmodule

// File: rtl/btb_predictor.sv
// Fully-associative branch target buffer with saturating direction counters
// and true-LRU replacement. Optional statistics counters under BTB_STATS_EN.
module btb_predictor
    import btb_pkg::*;
#(
    parameter int W_PC      = 8,
    parameter int W_BTA     = 32,
    parameter int N_ENTRIES = 4,
    parameter int CTR_BITS  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [W_PC-1:0]  pc,
    output logic             hit,
    output logic [W_BTA-1:0] bta,
    output logic             pred_taken,
    input  logic             upd_valid,
    input  logic [W_PC-1:0]  upd_pc,
    input  logic [W_BTA-1:0] upd_target,
    input  logic             upd_taken
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]      stat_lookups,
    output logic [31:0]      stat_hits,
    output logic [31:0]      stat_mispredicts
`endif
);

    localparam int AW = $clog2(N_ENTRIES);

    typedef struct packed {
        logic                valid;
        logic [W_PC-1:0]     tag;
        logic [W_BTA-1:0]    target;
        logic [CTR_BITS-1:0] ctr;
    } entry_t;

    entry_t                 ent [N_ENTRIES];
    logic [N_ENTRIES-1:0]   valid_vec;
    logic                   upd_hit;
    logic [AW-1:0]          upd_idx;
    logic                   touch_en;
    logic                   alloc_req;
    logic [AW-1:0]          victim_idx;
    logic [N_ENTRIES*AW-1:0] lru_ages;
    logic [CTR_BITS-1:0]    ctr_nxt;
    logic [CTR_BITS-1:0]    ctr_init;
    logic [N_ENTRIES-1:0]   age_seen;
    logic                   ages_ok;

    // Fetch lookup against registered state only; no same-cycle bypass.
    always_comb begin
        hit        = 1'b0;
        bta        = '0;
        pred_taken = 1'b0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            if (ent[i].valid && ent[i].tag == pc) begin
                hit        = 1'b1;
                bta        = ent[i].target;
                pred_taken = ent[i].ctr[CTR_BITS-1];
            end
        end
    end

    // Match the resolved branch against the table and derive the update action.
    always_comb begin
        upd_hit = 1'b0;
        upd_idx = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            valid_vec[i] = ent[i].valid;
            if (ent[i].valid && ent[i].tag == upd_pc) begin
                upd_hit = 1'b1;
                upd_idx = AW'(i);
            end
        end
        touch_en  = upd_valid & ~flush & upd_hit;
        alloc_req = upd_valid & ~flush & ~upd_hit & upd_taken;
        ctr_init  = CTR_BITS'(ctr_weak_taken(CTR_BITS));
        if (upd_taken)
            ctr_nxt = CTR_BITS'(ctr_sat_inc(32'(ent[upd_idx].ctr), CTR_BITS));
        else
            ctr_nxt = CTR_BITS'(ctr_sat_dec(32'(ent[upd_idx].ctr)));
    end

    btb_lru #(
        .N_ENTRIES (N_ENTRIES)
    ) u_lru (
        .clk        (clk),
        .reset      (reset),
        .touch_en   (touch_en),
        .touch_idx  (upd_idx),
        .alloc_req  (alloc_req),
        .valid      (valid_vec),
        .victim_idx (victim_idx),
        .ages       (lru_ages)
    );

    // Entry storage: reset clears, flush invalidates, updates train or allocate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_ENTRIES; i++)
                ent[i] <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < N_ENTRIES; i++)
                ent[i].valid <= 1'b0;
        end else if (touch_en) begin
            ent[upd_idx].target <= upd_target;
            ent[upd_idx].ctr    <= ctr_nxt;
        end else if (alloc_req) begin
            ent[victim_idx].valid  <= 1'b1;
            ent[victim_idx].tag    <= upd_pc;
            ent[victim_idx].target <= upd_target;
            ent[victim_idx].ctr    <= ctr_init;
        end
    end

    // Ages must always be a permutation of 0..N-1.
    always_comb begin
        age_seen = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++)
            age_seen[lru_ages[i*AW +: AW]] = 1'b1;
        ages_ok = &age_seen;
    end

    // Guard the LRU invariant during simulation.
    always_ff @(posedge clk) begin
        if (!reset)
            assert (ages_ok);
    end

`ifdef BTB_STATS_EN
    logic upd_pred;

    // Prediction the fetch side would have made for the resolved branch.
    always_comb begin
        upd_pred = upd_hit & ent[upd_idx].ctr[CTR_BITS-1];
    end

    // Statistics: survive flush, cleared only by reset, wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_lookups     <= '0;
            stat_hits        <= '0;
            stat_mispredicts <= '0;
        end else if (upd_valid) begin
            stat_lookups <= stat_lookups + 32'd1;
            if (upd_hit)
                stat_hits <= stat_hits + 32'd1;
            if (upd_pred != upd_taken)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: a behavioural model (MRU-ordered list
// for LRU) produces expected lookups, queued at drive and popped on sampling.
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [7:0]  pc;
    logic        hit;
    logic [31:0] bta;
    logic        pred_taken;
    logic        upd_valid;
    logic [7:0]  upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;

    btb_predictor #(
        .W_PC      (8),
        .W_BTA     (32),
        .N_ENTRIES (4),
        .CTR_BITS  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .pc         (pc),
        .hit        (hit),
        .bta        (bta),
        .pred_taken (pred_taken),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic        hit;
        logic [31:0] bta;
        logic        pt;
    } exp_t;
    exp_t sb[$];

    // reference model
    bit          m_valid [4];
    logic [7:0]  m_tag   [4];
    logic [31:0] m_tgt   [4];
    int          m_ctr   [4];
    int          mru[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
        end
        mru = {0, 1, 2, 3};
    endfunction

    function automatic void model_touch(input int k);
        for (int j = 0; j < mru.size(); j++)
            if (mru[j] == k) begin mru.delete(j); break; end
        mru.push_front(k);
    endfunction

    function automatic void model_update(input logic [7:0] t, input logic [31:0] tg,
                                         input bit tk, input bit fl);
        int k;
        k = -1;
        if (fl) begin
            for (int i = 0; i < 4; i++) m_valid[i] = 0;
            return;
        end
        for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == t) k = i;
        if (k >= 0) begin
            m_tgt[k] = tg;
            if (tk) m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
            else    m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
            model_touch(k);
        end else if (tk) begin
            k = mru[mru.size() - 1];
            for (int i = 3; i >= 0; i--) if (!m_valid[i]) k = i;
            m_valid[k] = 1; m_tag[k] = t; m_tgt[k] = tg; m_ctr[k] = 2;
            model_touch(k);
        end
    endfunction

    function automatic exp_t model_lookup(input string name, input logic [7:0] t);
        exp_t e;
        e.tag = name; e.hit = 0; e.bta = '0; e.pt = 0;
        for (int i = 0; i < 4; i++)
            if (m_valid[i] && m_tag[i] == t) begin
                e.hit = 1; e.bta = m_tgt[i]; e.pt = (m_ctr[i] >= 2);
            end
        return e;
    endfunction

    function automatic logic [7:0] model_ages();
        logic [7:0] a;
        a = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < mru.size(); j++)
                if (mru[j] == i) a[i*2 +: 2] = 2'(j);
        return a;
    endfunction

    logic [7:0]  p_pc;
    logic [31:0] p_tgt;
    bit          p_tk, p_fl;

    task automatic drive_upd(input logic [7:0] t, input logic [31:0] tg, input bit tk, input bit fl);
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = t; upd_target = tg; upd_taken = tk; flush = fl;
        p_pc = t; p_tgt = tg; p_tk = tk; p_fl = fl;
    endtask

    task automatic commit_upd();
        @(posedge clk);
        model_update(p_pc, p_tgt, p_tk, p_fl);
        #1;
        upd_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic upd(input logic [7:0] t, input logic [31:0] tg, input bit tk, input bit fl);
        drive_upd(t, tg, tk, fl);
        commit_upd();
    endtask

    task automatic lookup(input string name, input logic [7:0] t, input bit wait_edge);
        exp_t e;
        if (wait_edge) @(negedge clk);
        pc = t;
        sb.push_back(model_lookup(name, t));
        #1;
        e = sb.pop_front();
        check({e.tag, ".hit"}, 64'(hit), 64'(e.hit));
        check({e.tag, ".bta"}, 64'(bta), 64'(e.bta));
        check({e.tag, ".pt"},  64'(pred_taken), 64'(e.pt));
    endtask

    task automatic check_ages(input string name);
        #0;
        check(name, 64'(dut.lru_ages), 64'(model_ages()));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
        model_reset();
        #1;
        check("async_reset_hit", 64'(hit), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 1: reset state
        lookup("rst_08", 8'h08, 1);
        check("rst_ages_const", 64'(dut.lru_ages), 64'hE4);
        check_ages("rst_ages");

        // 2: allocate; same-cycle lookup sees old state
        drive_upd(8'h08, 32'h0000_0011, 1, 0);
        lookup("same_cycle_08", 8'h08, 0);
        commit_upd();
        lookup("alloc_08", 8'h08, 1);
        check("alloc_08_bta_const", 64'(bta), 64'h11);

        // 3: counter walk 10->01->00 then 01->10->11->11
        for (int i = 0; i < 2; i++) begin
            upd(8'h08, 32'h0000_0011, 0, 0);
            lookup($sformatf("nt%0d", i), 8'h08, 1);
        end
        for (int i = 0; i < 4; i++) begin
            upd(8'h08, 32'h0000_0022 + i, 1, 0);
            lookup($sformatf("tk%0d", i), 8'h08, 1);
        end

        // 4: LRU eviction
        do_reset();
        upd(8'h10, 32'h100, 1, 0);
        upd(8'h20, 32'h200, 1, 0);
        upd(8'h30, 32'h300, 1, 0);
        upd(8'h40, 32'h400, 1, 0);
        check_ages("fill_ages");
        upd(8'h10, 32'h101, 1, 0);
        upd(8'h50, 32'h500, 1, 0);
        lookup("evict_20", 8'h20, 1);
        check("evict_20_const", 64'(hit), 64'd0);
        lookup("keep_10", 8'h10, 1);
        lookup("keep_30", 8'h30, 1);
        lookup("keep_40", 8'h40, 1);
        lookup("new_50", 8'h50, 1);
        check_ages("evict_ages");

        // 5: not-taken miss does nothing; flush beats update
        upd(8'h60, 32'h600, 0, 0);
        lookup("nt_miss_60", 8'h60, 1);
        check_ages("nt_miss_ages");
        upd(8'h70, 32'h700, 1, 1);
        lookup("flush_70", 8'h70, 1);
        lookup("flush_10", 8'h10, 1);
        lookup("flush_50", 8'h50, 1);
        check_ages("flush_ages");
        upd(8'h90, 32'h900, 1, 0);
        lookup("post_flush_90", 8'h90, 1);
        check_ages("post_flush_ages");

        // 6: asynchronous reset with a pending update
        do_reset();
        upd(8'h08, 32'h0000_0011, 1, 0);
        drive_upd(8'h80, 32'h800, 1, 0);
        lookup("pre_arst_08", 8'h08, 0);
        #1;
        reset = 1'b1;
        model_reset();
        lookup("arst_08", 8'h08, 0);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        lookup("arst_lost_80", 8'h80, 1);
        check_ages("arst_ages");

        // random mix against the model
        for (int i = 0; i < 40; i++) begin
            logic [7:0] t;
            t = 8'(($urandom_range(0, 5)) * 16);
            upd(t, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            lookup($sformatf("rnd%0d", i), 8'(($urandom_range(0, 5)) * 16), 1);
        end
        check_ages("rnd_ages");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
